// File: rtl/seq1_pkg.sv
// Shared definitions for the serial sequence checker: state encoding and
// default reference pattern.
package seq1_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [7:0] DEF_PATTERN  = 8'b10011000;
    localparam int         DEF_LOSS_THR = 3;

endpackage

// File: rtl/seq1_chk.sv
// Serial pattern checker: acquires alignment to an 8-bit repeating sequence,
// then counts bit errors, reports clean periods and drops lock on error bursts.
module seq1_chk
    import seq1_pkg::*;
#(
    parameter logic [7:0] PATTERN  = DEF_PATTERN,
    parameter int         LOSS_THR = DEF_LOSS_THR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       din,
    input  logic       clr,
    output logic       lock,
    output logic [2:0] phase,
    output logic       err,
    output logic       frame_ok,
    output logic [7:0] err_cnt
);

    localparam logic [2:0] LOSS_THR_W = 3'(LOSS_THR);

    state_t     r_state;
    // Only the seven newest bits are ever compared; the eighth is the live din.
    logic [6:0] r_sr;
    logic [2:0] r_fill;
    logic [2:0] r_phase;
    logic [2:0] r_miss;
    logic       r_frame_err;
    logic       r_lock;
    logic       r_err;
    logic       r_frame_ok;
    logic [7:0] r_err_cnt;

    logic [7:0] w_window;
    logic       w_filled;
    logic       w_exp_bit;
    logic       w_mismatch;
    logic [2:0] w_miss_inc;
    logic       w_loss;

    assign w_window   = {r_sr, din};
    assign w_filled   = (r_fill == 3'd7);
    assign w_exp_bit  = PATTERN[3'd7 - r_phase];
    assign w_mismatch = (din != w_exp_bit);
    assign w_miss_inc = r_miss + 3'd1;
    assign w_loss     = (w_miss_inc == LOSS_THR_W);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= SEARCH;
            r_sr        <= '0;
            r_fill      <= '0;
            r_phase     <= '0;
            r_miss      <= '0;
            r_frame_err <= 1'b0;
            r_lock      <= 1'b0;
            r_err       <= 1'b0;
            r_frame_ok  <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_err      <= 1'b0;
            r_frame_ok <= 1'b0;
            if (en) begin
                r_sr <= w_window[6:0];
                if (!w_filled) begin
                    r_fill <= r_fill + 3'd1;
                end
                case (r_state)
                    SEARCH: begin
                        if (w_filled && (w_window == PATTERN)) begin
                            r_state     <= LOCKED;
                            r_lock      <= 1'b1;
                            r_phase     <= '0;
                            r_miss      <= '0;
                            r_frame_err <= 1'b0;
                        end
                    end
                    LOCKED: begin
                        if (w_mismatch) begin
                            r_err <= 1'b1;
                            if (r_err_cnt != 8'hFF) begin
                                r_err_cnt <= r_err_cnt + 8'd1;
                            end
                        end
                        if (w_mismatch && w_loss) begin
                            r_state     <= SEARCH;
                            r_lock      <= 1'b0;
                            r_phase     <= '0;
                            r_miss      <= '0;
                            r_frame_err <= 1'b0;
                        end else begin
                            r_phase <= r_phase + 3'd1;
                            r_miss  <= w_mismatch ? w_miss_inc : 3'd0;
                            // Period boundary: judge the finished period, start a fresh one.
                            if (r_phase == 3'd7) begin
                                r_frame_ok  <= !(r_frame_err || w_mismatch);
                                r_frame_err <= 1'b0;
                            end else if (w_mismatch) begin
                                r_frame_err <= 1'b1;
                            end
                        end
                    end
                    default: r_state <= SEARCH;
                endcase
            end
            // Clear beats a same-cycle increment.
            if (clr) begin
                r_err_cnt <= '0;
            end
        end
    end

    assign lock     = r_lock;
    assign phase    = r_phase;
    assign err      = r_err;
    assign frame_ok = r_frame_ok;
    assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_seq1_chk.sv
// Directed bench for seq1_chk: vector table for acquisition, steady state and
// enable gating, plus hand sequences for errors, loss, saturation and reset.
module tb_seq1_chk;

    localparam logic [7:0] PAT = 8'b10011000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic       din = 1'b0;
    logic       clr = 1'b0;
    logic       lock;
    logic [2:0] phase;
    logic       err;
    logic       frame_ok;
    logic [7:0] err_cnt;

    int checks = 0;
    int passes = 0;
    int pos    = 0;

    typedef struct {
        logic       en;
        logic       din;
        logic       clr;
        logic       lock;
        logic [2:0] phase;
        logic       err;
        logic       fok;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    seq1_chk dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .din      (din),
        .clr      (clr),
        .lock     (lock),
        .phase    (phase),
        .err      (err),
        .frame_ok (frame_ok),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic pbit(input int p);
        logic [7:0] pt;
        pt = PAT;
        return pt[7 - p];
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    task automatic step(input logic e, input logic d, input logic c);
        @(negedge clk);
        en  = e;
        din = d;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_ok();
        step(1'b1, pbit(pos), 1'b0);
        pos = (pos + 1) % 8;
    endtask

    task automatic send_bad();
        step(1'b1, ~pbit(pos), 1'b0);
        pos = (pos + 1) % 8;
    endtask

    function automatic vec_t mk(input logic e, input logic d, input logic l,
                                input int ph, input logic f);
        vec_t v;
        v.en = e; v.din = d; v.clr = 1'b0; v.lock = l;
        v.phase = 3'(ph); v.err = 1'b0; v.fok = f; v.cnt = 8'd0;
        return v;
    endfunction

    initial begin
        int tp;
        int exp_cnt;

        // Acquisition plus two locked periods.
        tp = 0;
        for (int i = 1; i <= 24; i++) begin
            vecs.push_back(mk(1'b1, pbit(tp), i >= 8, (i >= 8) ? (i - 8) % 8 : 0,
                              (i == 16) || (i == 24)));
            tp = (tp + 1) % 8;
        end
        // Three bits in, enable low for five cycles with wrong data, then finish the period.
        for (int i = 1; i <= 3; i++) begin
            vecs.push_back(mk(1'b1, pbit(tp), 1'b1, i, 1'b0));
            tp = (tp + 1) % 8;
        end
        for (int i = 0; i < 5; i++) begin
            vecs.push_back(mk(1'b0, ~pbit(tp), 1'b1, 3, 1'b0));
        end
        for (int i = 4; i <= 8; i++) begin
            vecs.push_back(mk(1'b1, pbit(tp), 1'b1, i % 8, i == 8));
            tp = (tp + 1) % 8;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_lock", lock, 0);
        check("rst_phase", phase, 0);
        check("rst_err", err, 0);
        check("rst_fok", frame_ok, 0);
        check("rst_cnt", err_cnt, 0);
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].din, vecs[i].clr);
            $display("vec %0d en=%0b din=%0b lock=%0b phase=%0d err=%0b fok=%0b cnt=%0d",
                     i, vecs[i].en, vecs[i].din, lock, phase, err, frame_ok, err_cnt);
            check($sformatf("v%0d_lock", i), lock, vecs[i].lock);
            check($sformatf("v%0d_phase", i), phase, vecs[i].phase);
            check($sformatf("v%0d_err", i), err, vecs[i].err);
            check($sformatf("v%0d_fok", i), frame_ok, vecs[i].fok);
            check($sformatf("v%0d_cnt", i), err_cnt, vecs[i].cnt);
        end
        pos = tp;

        // Single flipped bit at phase 3
        repeat (3) send_ok();
        send_bad();
        $display("flip@3 lock=%0b phase=%0d err=%0b cnt=%0d", lock, phase, err, err_cnt);
        check("flip_err", err, 1);
        check("flip_cnt", err_cnt, 1);
        check("flip_lock", lock, 1);
        check("flip_phase", phase, 4);
        repeat (3) send_ok();
        check("flip_noerr", err, 0);
        send_ok();
        $display("flip period end fok=%0b", frame_ok);
        check("flip_no_fok", frame_ok, 0);
        repeat (7) send_ok();
        check("clean_mid_fok", frame_ok, 0);
        send_ok();
        $display("clean period end fok=%0b phase=%0d", frame_ok, phase);
        check("clean_fok", frame_ok, 1);
        check("clean_phase", phase, 0);

        // Burst of three errors drops lock, then relock
        step(1'b0, 1'b0, 1'b1);
        $display("clr cnt=%0d lock=%0b phase=%0d", err_cnt, lock, phase);
        check("clr_cnt", err_cnt, 0);
        check("clr_lock", lock, 1);
        check("clr_phase", phase, 0);
        repeat (2) send_ok();
        for (int k = 1; k <= 3; k++) begin
            send_bad();
            $display("burst %0d lock=%0b err=%0b cnt=%0d phase=%0d", k, lock, err, err_cnt, phase);
            check($sformatf("burst%0d_err", k), err, 1);
            check($sformatf("burst%0d_cnt", k), err_cnt, k);
            check($sformatf("burst%0d_lock", k), lock, k < 3);
        end
        check("loss_phase", phase, 0);
        pos = 0;
        for (int k = 0; k < 8; k++) begin
            send_ok();
            $display("relock %0d lock=%0b", k, lock);
            check($sformatf("relock%0d", k), lock, k == 7);
        end
        check("relock_phase", phase, 0);
        check("relock_fok", frame_ok, 0);
        check("relock_cnt", err_cnt, 3);

        // Constant zero saturates the error counter
        exp_cnt = 3;
        for (int k = 0; k < 700; k++) begin
            if (pbit(pos) == 1'b1 && exp_cnt < 255) exp_cnt++;
            pos = (pos + 1) % 8;
            step(1'b1, 1'b0, 1'b0);
        end
        $display("zeros x700 lock=%0b cnt=%0d", lock, err_cnt);
        check("sat_lock", lock, 1);
        check("sat_cnt", err_cnt, exp_cnt);
        check("sat_phase", phase, pos);
        // Clear together with an error (phase 4 expects a 1)
        step(1'b1, 1'b0, 1'b1);
        pos = (pos + 1) % 8;
        $display("clr+err err=%0b cnt=%0d lock=%0b", err, err_cnt, lock);
        check("clrerr_err", err, 1);
        check("clrerr_cnt", err_cnt, 0);
        check("clrerr_lock", lock, 1);
        check("clrerr_phase", phase, 5);

        // Asynchronous reset between edges while locked
        send_ok();
        send_bad();
        check("pre_rst_cnt", err_cnt, 1);
        check("pre_rst_lock", lock, 1);
        #2;
        rst = 1'b0;
        en  = 1'b0;
        #1;
        $display("async rst lock=%0b cnt=%0d phase=%0d", lock, err_cnt, phase);
        check("arst_lock", lock, 0);
        check("arst_cnt", err_cnt, 0);
        check("arst_phase", phase, 0);
        @(negedge clk);
        rst = 1'b1;
        pos = 0;
        for (int k = 0; k < 8; k++) begin
            send_ok();
            $display("post-rst %0d lock=%0b", k, lock);
            check($sformatf("postrst%0d", k), lock, k == 7);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
